// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: captures one entry per rising edge of
// new_data and presents the oldest entry first-word-fall-through to the host.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int AFULL_LVL  = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            data_i,
   input  logic                  valid_i,
   input  logic                  parity_en,
   input  logic                  new_data,
   input  logic                  rd,
   input  logic                  flush,
   input  logic                  overflow_clr,
   output logic [7:0]            data_o,
   output logic                  perr_o,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  afull,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic [7:0]            perr_cnt
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   AFULL_THR = (DEPTH_LOG2 + 1)'(AFULL_LVL);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

   // Each entry is {parity_error, data_byte}.
   logic [8:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  new_data_d;

   logic push;
   logic pop;
   logic push_ok;
   logic drop;
   logic perr_in;
   logic is_full;

   assign push    = new_data & ~new_data_d;
   assign perr_in = parity_en & ~valid_i;
   assign is_full = (count == FULL_LVL);
   assign pop     = rd & rd_valid;
   // A pop on the same edge frees the slot, so a push into a full FIFO survives.
   assign push_ok = push & (~is_full | pop);
   assign drop    = push & is_full & ~pop;

   assign rd_valid = (count != '0);
   assign full     = is_full;
   assign afull    = (count >= AFULL_THR);
   assign data_o   = rd_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign perr_o   = rd_valid & mem[rd_ptr][8];

   // NOTE: storage has no reset; validity is tracked by count, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= {perr_in, data_i};
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         new_data_d <= 1'b0;
         overflow   <= 1'b0;
         perr_cnt   <= 8'h00;
      end else begin
         new_data_d <= new_data;
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            perr_cnt <= 8'h00;
         end else begin
            if (push_ok) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push_ok, pop})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: count <= count;
            endcase
            // A new drop wins over a simultaneous clear.
            if (drop) begin
               overflow <= 1'b1;
            end else if (overflow_clr) begin
               overflow <= 1'b0;
            end
            if (push_ok && perr_in && (perr_cnt != 8'hFF)) begin
               perr_cnt <= perr_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AFULL = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       valid_i = 1'b1;
   logic       parity_en = 1'b0;
   logic       new_data = 1'b0;
   logic       rd = 1'b0;
   logic       flush = 1'b0;
   logic       overflow_clr = 1'b0;
   logic [7:0] data_o;
   logic       perr_o;
   logic       rd_valid;
   logic       full;
   logic       afull;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] perr_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [8:0] m_q[$];
   logic       m_ovf = 1'b0;
   int         m_pcnt = 0;
   logic       m_prev_nd = 1'b0;

   uart_rx_fifo #(.DEPTH_LOG2(4), .AFULL_LVL(AFULL)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .parity_en(parity_en),
      .new_data(new_data), .rd(rd), .flush(flush), .overflow_clr(overflow_clr),
      .data_o(data_o), .perr_o(perr_o), .rd_valid(rd_valid), .full(full), .afull(afull),
      .count(count), .overflow(overflow), .perr_cnt(perr_cnt)
   );

   always #5 clk = ~clk;

   function automatic void model_update();
      logic push, do_pop, acc, perr;
      if (!rst) begin
         m_q.delete(); m_ovf = 1'b0; m_pcnt = 0; m_prev_nd = 1'b0;
         return;
      end
      push = new_data && !m_prev_nd;
      m_prev_nd = new_data;
      if (flush) begin
         m_q.delete(); m_ovf = 1'b0; m_pcnt = 0;
         return;
      end
      perr   = parity_en && !valid_i;
      do_pop = rd && (m_q.size() != 0);
      acc    = push && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (acc) begin
         m_q.push_back({perr, data_i});
         if (perr && m_pcnt < 255) m_pcnt++;
      end
      if (push && !acc) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
   endfunction

   // Apply current inputs for one clock; return 1 ns after the edge.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic v, input logic pen);
      data_i = d; valid_i = v; parity_en = pen; new_data = 1'b1;
      step();
      new_data = 1'b0;
      step();
   endtask

   task automatic pop_one();
      rd = 1'b1;
      step();
      rd = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(); step();
      n_vec++; if (count !== 5'd0)   begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
      n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
      n_vec++; if (data_o !== 8'h00 || perr_o !== 1'b0) begin n_err++; $display("FAIL reset_mask got %h/%b exp 00/0", data_o, perr_o); end
      n_vec++; if ({full, afull, overflow} !== 3'b000 || perr_cnt !== 8'h00) begin n_err++; $display("FAIL reset_flags got f%b af%b ov%b pc%h exp all 0", full, afull, overflow, perr_cnt); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single_byte();
      data_i = 8'hA5; valid_i = 1'b1; parity_en = 1'b1; new_data = 1'b1;
      step();
      new_data = 1'b0;
      n_vec++; if (rd_valid !== 1'b1 || count !== 5'd1) begin n_err++; $display("FAIL single_push got v%b c%0d exp v1 c1", rd_valid, count); end
      n_vec++; if (data_o !== 8'hA5 || perr_o !== 1'b0) begin n_err++; $display("FAIL single_data got %h/%b exp a5/0", data_o, perr_o); end
      pop_one();
      n_vec++; if (rd_valid !== 1'b0 || data_o !== 8'h00 || count !== 5'd0) begin n_err++; $display("FAIL single_pop got v%b d%h c%0d exp v0 d00 c0", rd_valid, data_o, count); end
      // rd while empty: no effect
      pop_one();
      n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_rd got c%0d v%b exp c0 v0", count, rd_valid); end
   endtask

   task automatic test_fill_overflow();
      do_flush();
      for (int i = 0; i <= DEPTH; i++) begin
         int exp_c;
         push_byte(8'(i), 1'b1, 1'b0);
         exp_c = (i + 1 > DEPTH) ? DEPTH : i + 1;
         n_vec++; if (count !== 5'(exp_c)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, exp_c); end
         n_vec++; if (afull !== (exp_c >= AFULL) || full !== (exp_c == DEPTH)) begin n_err++; $display("FAIL fill_flags[%0d] got af%b f%b exp af%b f%b", i, afull, full, exp_c >= AFULL, exp_c == DEPTH); end
      end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow got %b exp 1", overflow); end
      for (int j = 0; j < DEPTH; j++) begin
         n_vec++; if (data_o !== 8'(j) || rd_valid !== 1'b1) begin n_err++; $display("FAIL drain[%0d] got %h v%b exp %h v1", j, data_o, rd_valid, 8'(j)); end
         pop_one();
      end
      n_vec++; if (count !== 5'd0 || overflow !== 1'b1) begin n_err++; $display("FAIL drain_end got c%0d ov%b exp c0 ov1", count, overflow); end
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b exp 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      do_flush();
      for (int i = 0; i < DEPTH; i++) push_byte(8'h40 + 8'(i), 1'b1, 1'b0);
      data_i = 8'h99; new_data = 1'b1; rd = 1'b1;
      step();
      new_data = 1'b0; rd = 1'b0;
      n_vec++; if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin n_err++; $display("FAIL fullpp got c%0d ov%b f%b exp c16 ov0 f1", count, overflow, full); end
      for (int j = 0; j < DEPTH; j++) begin
         logic [7:0] exp_d;
         exp_d = (j == DEPTH - 1) ? 8'h99 : 8'h41 + 8'(j);
         n_vec++; if (data_o !== exp_d) begin n_err++; $display("FAIL fullpp_drain[%0d] got %h exp %h", j, data_o, exp_d); end
         pop_one();
      end
   endtask

   task automatic test_parity();
      logic exp_p [4];
      exp_p = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_flush();
      for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b1);
      push_byte(8'h20, 1'b0, 1'b0);
      n_vec++; if (perr_cnt !== 8'd3) begin n_err++; $display("FAIL perr_cnt3 got %0d exp 3", perr_cnt); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (perr_o !== exp_p[i]) begin n_err++; $display("FAIL perr_tag[%0d] got %b exp %b", i, perr_o, exp_p[i]); end
         pop_one();
      end
      for (int i = 0; i < 300; i++) begin
         data_i = 8'($urandom); valid_i = 1'b0; parity_en = 1'b1; new_data = 1'b1;
         step();
         new_data = 1'b0; rd = 1'b1;
         step();
         rd = 1'b0;
         if (i == 200) begin
            n_vec++; if (perr_cnt !== 8'd204) begin n_err++; $display("FAIL perr_cnt204 got %0d exp 204", perr_cnt); end
         end
      end
      n_vec++; if (perr_cnt !== 8'hFF) begin n_err++; $display("FAIL perr_sat got %h exp ff", perr_cnt); end
      valid_i = 1'b1;
   endtask

   task automatic test_wide_strobe();
      do_flush();
      data_i = 8'h3C; new_data = 1'b1;
      repeat (5) step();
      new_data = 1'b0;
      step();
      n_vec++; if (count !== 5'd1 || data_o !== 8'h3C) begin n_err++; $display("FAIL wide got c%0d d%h exp c1 d3c", count, data_o); end
   endtask

   task automatic test_flush();
      do_flush();
      for (int i = 0; i <= DEPTH; i++) push_byte(8'(i), 1'b0, 1'b1);
      repeat (11) pop_one();
      n_vec++; if (count !== 5'd5 || overflow !== 1'b1) begin n_err++; $display("FAIL preflush got c%0d ov%b exp c5 ov1", count, overflow); end
      data_i = 8'h77; flush = 1'b1; new_data = 1'b1;
      step();
      flush = 1'b0;
      n_vec++; if (count !== 5'd0 || overflow !== 1'b0 || perr_cnt !== 8'h00 || rd_valid !== 1'b0) begin n_err++; $display("FAIL flush got c%0d ov%b pc%0d v%b exp all 0", count, overflow, perr_cnt, rd_valid); end
      step();  // strobe still held high: must not push
      new_data = 1'b0;
      n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL flush_held got c%0d exp 0", count); end
      valid_i = 1'b1; parity_en = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1'b0, 1'b1);
      overflow_clr = 1'b0;
      #2 rst = 1'b0;
      model_update();
      #1;
      n_vec++; if (count !== 5'd0 || rd_valid !== 1'b0 || data_o !== 8'h00 || perr_cnt !== 8'h00) begin n_err++; $display("FAIL async_rst got c%0d v%b d%h pc%0d exp 0", count, rd_valid, data_o, perr_cnt); end
      step();
      rst = 1'b1;
      push_byte(8'h5A, 1'b1, 1'b0);
      n_vec++; if (count !== 5'd1 || data_o !== 8'h5A) begin n_err++; $display("FAIL post_rst got c%0d d%h exp c1 d5a", count, data_o); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         int rd_pct;
         rd_pct = ((i / 250) % 2 == 0) ? 15 : 70;
         data_i = 8'($urandom);
         valid_i = 1'($urandom);
         parity_en = 1'($urandom);
         new_data = ($urandom_range(99) < 50);
         rd = ($urandom_range(99) < rd_pct);
         flush = ($urandom_range(199) == 0);
         overflow_clr = ($urandom_range(15) == 0);
         step();
         begin
            logic [7:0] e_d;
            logic       e_p;
            e_d = (m_q.size() != 0) ? m_q[0][7:0] : 8'h00;
            e_p = (m_q.size() != 0) ? m_q[0][8] : 1'b0;
            n_vec++; if (count !== 5'(m_q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, m_q.size()); end
            n_vec++; if (data_o !== e_d || perr_o !== e_p || rd_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_head[%0d] got %h/%b/%b exp %h/%b/%b", i, data_o, perr_o, rd_valid, e_d, e_p, m_q.size() != 0); end
            n_vec++; if (full !== (m_q.size() == DEPTH) || afull !== (m_q.size() >= AFULL)) begin n_err++; $display("FAIL rnd_flags[%0d] got f%b af%b", i, full, afull); end
            n_vec++; if (overflow !== m_ovf || perr_cnt !== 8'(m_pcnt)) begin n_err++; $display("FAIL rnd_stat[%0d] got ov%b pc%0d exp ov%b pc%0d", i, overflow, perr_cnt, m_ovf, m_pcnt); end
         end
      end
      new_data = 1'b0; rd = 1'b0; flush = 1'b0; overflow_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_fill_overflow();
      test_full_push_pop();
      test_parity();
      test_wide_strobe();
      test_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
